// File: rtl/mem_bus_arbiter.sv
// Two-master (fetch/load-store) arbiter onto one memory slave, one outstanding txn.
// Define MEM_BUS_ARBITER_RR_EN for round-robin instead of fixed priority + starvation guard.
`timescale 1ns/1ps
module mem_bus_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            m0_req_i,
  input  logic [AW-1:0]   m0_addr_i,
  output logic            m0_gnt_o,
  output logic            m0_rvalid_o,
  output logic [DW-1:0]   m0_rdata_o,
  input  logic            m1_req_i,
  input  logic            m1_we_i,
  input  logic [DW/8-1:0] m1_be_i,
  input  logic [AW-1:0]   m1_addr_i,
  input  logic [DW-1:0]   m1_wdata_i,
  output logic            m1_gnt_o,
  output logic            m1_rvalid_o,
  output logic [DW-1:0]   m1_rdata_o,
  output logic            s_req_o,
  output logic            s_we_o,
  output logic [DW/8-1:0] s_be_o,
  output logic [AW-1:0]   s_addr_o,
  output logic [DW-1:0]   s_wdata_o,
  input  logic            s_ready_i,
  input  logic            s_rvalid_i,
  input  logic [DW-1:0]   s_rdata_i,
  output logic            hold_flag_o
);

  localparam int BW = DW / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic            owner_q, owner_d;
  logic            we_q, we_d;
  logic [BW-1:0]   be_q, be_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;

  logic            any_req;
  logic            m0_win;
  logic            accept;
  logic            done;

`ifdef MEM_BUS_ARBITER_RR_EN
  logic            last_q, last_d;

  // On contention the master that did not win last time goes first.
  assign m0_win = m0_req_i & (!m1_req_i | last_q);
`else
  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  logic [SW-1:0]   starve_q, starve_d;
  logic            starved;

  assign starved = 32'(starve_q) >= 32'(STARVE_MAX);
  assign m0_win  = m0_req_i & (!m1_req_i | starved);
`endif

  assign any_req = m0_req_i | m1_req_i;

  // State and latched-transaction registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      we_q     <= 1'b0;
      be_q     <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
`ifdef MEM_BUS_ARBITER_RR_EN
      last_q   <= 1'b0;
`else
      starve_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      we_q     <= we_d;
      be_q     <= be_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
`ifdef MEM_BUS_ARBITER_RR_EN
      last_q   <= last_d;
`else
      starve_q <= starve_d;
`endif
    end
  end

  // Next-state and arbitration.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    we_d     = we_q;
    be_d     = be_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
`ifdef MEM_BUS_ARBITER_RR_EN
    last_d   = last_q;
`else
    starve_d = starve_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = REQ;
          owner_d = !m0_win;
          if (m0_win) begin
            we_d    = 1'b0;
            be_d    = '1;
            addr_d  = m0_addr_i;
            wdata_d = '0;
          end else begin
            we_d    = m1_we_i;
            be_d    = m1_be_i;
            addr_d  = m1_addr_i;
            wdata_d = m1_wdata_i;
          end
`ifdef MEM_BUS_ARBITER_RR_EN
          last_d = !m0_win;
`else
          if (m0_win) begin
            starve_d = '0;
          end else if (m0_req_i && !starved) begin
            starve_d = starve_q + SW'(1);
          end
`endif
        end
      end
      REQ: begin
        if (s_ready_i) begin
          state_d = s_rvalid_i ? IDLE : RESP;
        end
      end
      RESP: begin
        if (s_rvalid_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: grant and response are steered to the latched owner only.
  always_comb begin
    s_req_o     = (state_q == REQ);
    s_we_o      = we_q;
    s_be_o      = be_q;
    s_addr_o    = addr_q;
    s_wdata_o   = wdata_q;
    accept      = s_req_o & s_ready_i;
    done        = (accept & s_rvalid_i)
                | ((state_q == RESP) & s_rvalid_i);
    m0_gnt_o    = accept & !owner_q;
    m1_gnt_o    = accept & owner_q;
    m0_rvalid_o = done & !owner_q;
    m1_rvalid_o = done & owner_q;
    m0_rdata_o  = m0_rvalid_o ? s_rdata_i : '0;
    m1_rdata_o  = m1_rvalid_o ? s_rdata_i : '0;
    hold_flag_o = (m0_req_i & !m0_rvalid_o)
                | (m1_req_i & !m1_rvalid_o);
  end

  a_gnt_onehot: assert property (
    @(posedge clk) disable iff (rst) !(m0_gnt_o && m1_gnt_o));
  a_rv_onehot: assert property (
    @(posedge clk) disable iff (rst) !(m0_rvalid_o && m1_rvalid_o));

endmodule
